// File: rtl/mem_port_arbiter.sv
// Shares one single-beat AXI4 master port between fetch (m0, read-only) and exec (m1, read/write); one transfer in flight.
// Optional ARB_ROUND_ROBIN_EN: ties alternate between requesters; default is fixed priority m1 > m0.
module mem_port_arbiter #(
   parameter int ADDR_W = 22
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic              m0_done,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_byte,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_done,
   output logic [31:0]       rd_data,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [31:0]       rdata,
   input  logic              rvalid,
   output logic              rready,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [31:0]       wdata,
   output logic              wvalid,
   input  logic              wready,
   input  logic              bvalid,
   output logic              bready,
   output logic [2:0]        axsize
);

   localparam logic [2:0] SIZE_WORD = 3'b010;
   localparam logic [2:0] SIZE_BYTE = 3'b000;

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t state_q;
   logic   owner_q;
   logic   grant_m1;

`ifdef ARB_ROUND_ROBIN_EN
   logic   prio_q;   // requester that wins the next tie (1 = m1)
   assign grant_m1 = m1_req & (~m0_req | prio_q);
`else
   assign grant_m1 = m1_req;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         prio_q  <= 1'b1;
`endif
         m0_done <= 1'b0;
         m1_done <= 1'b0;
         rd_data <= '0;
         araddr  <= '0;
         arvalid <= 1'b0;
         rready  <= 1'b0;
         awaddr  <= '0;
         awvalid <= 1'b0;
         wdata   <= '0;
         wvalid  <= 1'b0;
         bready  <= 1'b0;
         axsize  <= SIZE_WORD;
      end else begin
         m0_done <= 1'b0;
         m1_done <= 1'b0;
         case (state_q)
            IDLE: begin
               // The done cycle is skipped so the finished requester can drop its req first.
               if (!(m0_done || m1_done) && (m0_req || m1_req)) begin
                  owner_q <= grant_m1;
`ifdef ARB_ROUND_ROBIN_EN
                  prio_q  <= ~grant_m1;
`endif
                  if (grant_m1 && m1_we) begin
                     awaddr  <= m1_addr;
                     wdata   <= m1_wdata;
                     axsize  <= m1_byte ? SIZE_BYTE : SIZE_WORD;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     bready  <= 1'b1;
                     state_q <= WR;
                  end else begin
                     araddr  <= grant_m1 ? m1_addr : m0_addr;
                     axsize  <= (grant_m1 && m1_byte) ? SIZE_BYTE : SIZE_WORD;
                     arvalid <= 1'b1;
                     rready  <= 1'b1;
                     state_q <= RD;
                  end
               end
            end
            RD: begin
               if (arvalid && arready) arvalid <= 1'b0;
               if (rvalid && rready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b0;
                  rd_data <= rdata;
                  m0_done <= ~owner_q;
                  m1_done <= owner_q;
                  state_q <= IDLE;
               end
            end
            WR: begin
               if (awvalid && awready) awvalid <= 1'b0;
               if (wvalid && wready)   wvalid  <= 1'b0;
               // An early response closes the transfer regardless of pending aw/w handshakes.
               if (bvalid && bready) begin
                  awvalid <= 1'b0;
                  wvalid  <= 1'b0;
                  bready  <= 1'b0;
                  m1_done <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
